// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and helpers for the instruction fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int WORD_W      = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : circular FIFO of fetched {pc, instr} entries with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_data,
   output logic         full,
   output logic         empty,
   output logic [3:0]   count,
   output fetch_entry_t head
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [3:0]       C_DEPTH = 4'(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [3:0]       r_count;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == C_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == C_DEPTH);
   assign empty = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit : PC register, push/redirect arbitration, fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [WORD_W-1:0] imem_pc,
   input  logic [WORD_W-1:0] imem_instr,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [WORD_W-1:0] id_instr,
   output logic [WORD_W-1:0] id_pc,
   output logic [WORD_W-1:0] id_pc_plus4,
   output logic [3:0]        buf_count
);

   logic [WORD_W-1:0] r_pc;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   fetch_entry_t      w_wr_entry;
   fetch_entry_t      w_head;

   // A pop frees a slot in the same cycle, so a full buffer can still accept.
   assign w_pop      = !w_empty & id_ready;
   assign w_push     = !redirect_valid & (!w_full | w_pop);
   assign w_wr_entry = '{pc: r_pc, instr: imem_instr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= align_word(redirect_pc);
      end else if (w_push) begin
         r_pc <= r_pc + 32'(INSTR_BYTES);
      end
   end

   fetch_buffer #(
      .DEPTH   (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (redirect_valid),
      .wr_data (w_wr_entry),
      .full    (w_full),
      .empty   (w_empty),
      .count   (buf_count),
      .head    (w_head)
   );

   assign imem_pc     = r_pc;
   assign id_valid    = !w_empty;
   assign id_instr    = w_head.instr;
   assign id_pc       = w_head.pc;
   assign id_pc_plus4 = w_head.pc + 32'(INSTR_BYTES);

endmodule

`default_nettype wire
